// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder: lower half resolves in stage 1,
// upper half in stage 2, valid/ready on both sides with full throughput.
module cla_pipe_adder #(
   parameter int unsigned WIDTH = 16   // multiple of 8
) (
   input  logic             clk,
   input  logic             sync_reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned NGRP = HALF / 4;

   // Half-width two-level lookahead adder; returns {carry_out, sum}
   function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                              input logic [HALF-1:0] y,
                                              input logic            ci);
      logic [HALF-1:0] g, p, c;
      logic [NGRP-1:0] gg, gp;
      logic [NGRP:0]   gc;
      logic            term;
      g = x & y;
      p = x ^ y;
      for (int unsigned k = 0; k < NGRP; k++) begin
         gg[k] = 1'b0;
         gp[k] = 1'b1;
         for (int unsigned i = 0; i < 4; i++) begin
            gg[k] = g[4*k+i] | (p[4*k+i] & gg[k]);
            gp[k] = gp[k] & p[4*k+i];
         end
      end
      // Each group carry is a flat sum of products over group G/P terms
      for (int unsigned k = 0; k <= NGRP; k++) begin
         term = ci;
         for (int unsigned m = 0; m < k; m++) term = term & gp[m];
         gc[k] = term;
         for (int unsigned j = 0; j < k; j++) begin
            term = gg[j];
            for (int unsigned m = j + 1; m < k; m++) term = term & gp[m];
            gc[k] = gc[k] | term;
         end
      end
      for (int unsigned k = 0; k < NGRP; k++) begin
         c[4*k] = gc[k];
         for (int unsigned i = 1; i < 4; i++)
            c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
      end
      return {gc[NGRP], p ^ c};
   endfunction

   logic            s1_valid;
   logic [HALF-1:0] lo_sum;
   logic            c_mid;
   logic [HALF-1:0] a_hi;
   logic [HALF-1:0] b_hi;

   logic            s2_adv;
   logic            s1_adv;
   logic            accept;
   logic [HALF:0]   lo_res;
   logic [HALF:0]   hi_res;

   always_comb begin
      s2_adv   = !out_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      in_ready = s1_adv;
      accept   = in_valid && s1_adv;
      lo_res   = cla_half(a[HALF-1:0], b[HALF-1:0], cin);
      hi_res   = cla_half(a_hi, b_hi, c_mid);
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         s1_valid  <= 1'b0;
         lo_sum    <= '0;
         c_mid     <= 1'b0;
         a_hi      <= '0;
         b_hi      <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         s1_valid <= accept || (s1_valid && !s2_adv);
         if (accept) begin
            lo_sum <= lo_res[HALF-1:0];
            c_mid  <= lo_res[HALF];
            a_hi   <= a[WIDTH-1:HALF];
            b_hi   <= b[WIDTH-1:HALF];
         end
         if (s2_adv) out_valid <= s1_valid;
         if (s2_adv && s1_valid) begin
            sum  <= {hi_res[HALF-1:0], lo_sum};
            cout <= hi_res[HALF];
            ovf  <= (a_hi[HALF-1] == b_hi[HALF-1]) && (hi_res[HALF-1] != a_hi[HALF-1]);
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector bench for cla_pipe_adder: reset, boundaries, streaming,
// back-pressure and mid-stream reset.
module tb_cla_pipe_adder;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         sync_reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(W)) dut (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .cin          (cin),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sum          (sum),
      .cout         (cout),
      .ovf          (ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sync_reset_n = 1'b0;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      cin          = 1'b1;
      a            = W'($urandom);
      b            = W'($urandom);
      step();
      a = W'($urandom);
      b = W'($urandom);
      step();
      checks++;
      if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
      checks++;
      if ({cout, ovf, out_valid} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got cout/ovf/out_valid=%b expected 000", {cout, ovf, out_valid});
      end
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      sync_reset_n = 1'b1;
      in_valid     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_spurious_valid cycle %0d: got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_vector(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vc, input logic [W-1:0] es, input logic ec, input logic eo);
      a = va; b = vb; cin = vc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
      step();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b expected 0", name, out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, out_valid); end
      checks++;
      if (sum !== es) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, sum, es); end
      checks++;
      if ({cout, ovf} !== {ec, eo}) begin
         errors++; $display("FAIL %s_cout_ovf: got %b%b expected %b%b", name, cout, ovf, ec, eo);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b expected 0", name, out_valid); end
   endtask

   task automatic test_boundaries();
      test_vector("ffff_p1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_vector("7fff_p1",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      test_vector("8000_x2",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      test_vector("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_half_carry();
      test_vector("00ff_cin", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
      test_vector("0fff_p1",  16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_sum;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c >= 2) begin
            exp_sum = W'(4 * (c - 2) + ((c - 2) % 2));
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b expected 1", c, out_valid); end
            checks++;
            if (sum !== exp_sum) begin errors++; $display("FAIL stream_sum c%0d: got %h expected %h", c, sum, exp_sum); end
         end
         if (c < 8) begin
            a = W'(c); b = W'(3 * c); cin = 1'(c % 2);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b expected 1", c, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      logic fire;
      logic prev_stall = 1'b0;
      logic saw_low = 1'b0;
      logic [W-1:0] held = '0;
      while (rx < 8 && cyc < 40) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         in_valid  = (tx < 8);
         a   = 16'h1000;
         b   = W'(tx);
         cin = 1'b0;
         #1;
         if (out_valid && !out_ready) begin
            if (prev_stall) begin
               checks++;
               if (sum !== held) begin errors++; $display("FAIL bp_hold c%0d: got %h expected %h", cyc, sum, held); end
            end
            held       = sum;
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sum !== W'(16'h1000 + rx)) begin
               errors++; $display("FAIL bp_order rx%0d: got %h expected %h", rx, sum, W'(16'h1000 + rx));
            end
            rx++;
         end
         if (cyc == 4) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
         end
         if (!in_ready) saw_low = 1'b1;
         fire = in_valid && in_ready;
         step();
         if (fire) tx++;
         cyc++;
      end
      checks++;
      if (rx != 8) begin errors++; $display("FAIL bp_count: got %0d results expected 8", rx); end
      checks++;
      if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_saw_in_ready_low: got %b expected 1", saw_low); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      cin       = 1'b0;
      for (int c = 0; c < 3; c++) begin
         a = 16'h2222; b = W'(c + 1);
         in_valid = 1'b1;
         step();
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
      sync_reset_n = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
      checks++;
      if ({sum, cout, ovf} !== 18'h0) begin
         errors++; $display("FAIL midrst_data: got sum=%h cout=%b ovf=%b expected 0", sum, cout, ovf);
      end
      sync_reset_n = 1'b1;
      in_valid     = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial: got %b expected 0", out_valid); end
      test_vector("midrst_after", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
   endtask

   initial begin
      sync_reset_n = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      a            = '0;
      b            = '0;
      cin          = 1'b0;
      test_reset();
      test_boundaries();
      test_half_carry();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
